// File: rtl/sti_pkg.sv
// rtl/sti_pkg.sv - shared length codes, FSM states and helpers for the serial transmitter
package sti_pkg;

    localparam logic [1:0] LEN_8  = 2'b00;
    localparam logic [1:0] LEN_16 = 2'b01;
    localparam logic [1:0] LEN_24 = 2'b10;
    localparam logic [1:0] LEN_32 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [5:0] len_to_bits(input logic [1:0] code);
        logic [5:0] bits;
        case (code)
            LEN_8:   bits = 6'd8;
            LEN_16:  bits = 6'd16;
            LEN_24:  bits = 6'd24;
            default: bits = 6'd32;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/sti_frame_fmt.sv
// rtl/sti_frame_fmt.sv - combinational mapping of the host word and framing controls to a frame
module sti_frame_fmt
    import sti_pkg::*;
(
    input  logic [15:0] pi_data_i,
    input  logic [1:0]  pi_length_i,
    input  logic        pi_fill_i,
    input  logic        pi_low_i,
    output logic [31:0] frame_o,
    output logic [5:0]  nbits_o
);

    always_comb begin
        frame_o = '0;
        case (pi_length_i)
            LEN_8:   frame_o[7:0]   = pi_low_i ? pi_data_i[15:8] : pi_data_i[7:0];
            LEN_16:  frame_o[15:0]  = pi_data_i;
            LEN_24:  frame_o[23:0]  = pi_fill_i ? {pi_data_i, 8'h00} : {8'h00, pi_data_i};
            default: frame_o        = pi_fill_i ? {pi_data_i, 16'h0000} : {16'h0000, pi_data_i};
        endcase
    end

    assign nbits_o = len_to_bits(pi_length_i);

endmodule

// File: rtl/sti_serializer.sv
// rtl/sti_serializer.sv - parallel-to-serial frame transmitter with registered strobe outputs
module sti_serializer
    import sti_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        pi_load,
    input  logic [15:0] pi_data,
    input  logic [1:0]  pi_length,
    input  logic        pi_fill,
    input  logic        pi_msb,
    input  logic        pi_low,
    output logic        so_data,
    output logic        so_valid,
    output logic        so_last,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] frame_q, frame_d;
    logic [5:0]  nbits_q, nbits_d;
    logic        msb_q, msb_d;
    logic        so_data_q, so_data_d;
    logic        so_valid_q, so_valid_d;
    logic        so_last_q, so_last_d;
    logic        busy_q, busy_d;

    logic [31:0] fmt_frame;
    logic [5:0]  fmt_nbits;
    logic [4:0]  last_idx;
    logic [4:0]  bit_idx;

    sti_frame_fmt u_fmt (
        .pi_data_i   (pi_data),
        .pi_length_i (pi_length),
        .pi_fill_i   (pi_fill),
        .pi_low_i    (pi_low),
        .frame_o     (fmt_frame),
        .nbits_o     (fmt_nbits)
    );

    // Counter is a bit ordinal; direction maps it onto the frame position.
    assign last_idx = 5'(nbits_q - 6'd1);
    assign bit_idx  = msb_q ? (last_idx - cnt_q) : cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        nbits_d    = nbits_q;
        msb_d      = msb_q;
        busy_d     = busy_q;
        so_data_d  = 1'b0;
        so_valid_d = 1'b0;
        so_last_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pi_load) begin
                    frame_d = fmt_frame;
                    nbits_d = fmt_nbits;
                    msb_d   = pi_msb;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                so_valid_d = 1'b1;
                so_data_d  = frame_q[bit_idx];
                if (cnt_q == last_idx) begin
                    so_last_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            frame_q    <= 32'd0;
            nbits_q    <= 6'd0;
            msb_q      <= 1'b0;
            so_data_q  <= 1'b0;
            so_valid_q <= 1'b0;
            so_last_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            nbits_q    <= nbits_d;
            msb_q      <= msb_d;
            so_data_q  <= so_data_d;
            so_valid_q <= so_valid_d;
            so_last_q  <= so_last_d;
            busy_q     <= busy_d;
        end
    end

    assign so_data  = so_data_q;
    assign so_valid = so_valid_q;
    assign so_last  = so_last_q;
    assign busy     = busy_q;

endmodule
